edge_event_scheduler: RTL

Multi-channel edge-event controller that sequences the edge-detection datapath for N asynchronous level inputs such as buttons and switches. Each channel is synchronized, rising edges are detected, and each edge is latched as a pending event. A round-robin arbiter then shares a single valid/ready event port between the channels, so the downstream consumer sees one channel ID per transfer. Lost events are flagged per channel.

---
 rtl/edge_event_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/edge_event_scheduler.sv
// edge_event_scheduler: N-channel level-to-event controller.
// Each channel synchronizes an asynchronous level, detects rising edges and
// latches them as pending events. A two-state round-robin arbiter hands the
// pending events one at a time to a single valid/ready port.

// Per-channel datapath: synchronizer, edge detector, pending and overflow.
module edge_event_lane #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic level,
   input  logic enable,
   input  logic clr,             // accepted transfer for this channel
   input  logic clear_overflow,
   output logic pending,
   output logic overflow
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync;
   logic                   rise;

   assign sync = sync_q[SYNC_STAGES-1];
   // enable only masks new edges; an event already pending is kept
   assign rise = sync & ~prev_q & enable;

   // Synchronizer chain and previous-value flop. prev resets to 0 so a level
   // held high through reset release counts as a rising edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], level};
         prev_q <= sync;
      end
   end

   // Pending flag: a new edge wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset)
         pending <= 1'b0;
      else if (rise)
         pending <= 1'b1;
      else if (clr)
         pending <= 1'b0;
   end

   // Sticky lost-event flag: an edge landing on a pending event that is not
   // being retired this cycle. A set beats a same-cycle clear_overflow.
   always_ff @(posedge clk) begin
      if (reset)
         overflow <= 1'b0;
      else if (rise & pending & ~clr)
         overflow <= 1'b1;
      else if (clear_overflow)
         overflow <= 1'b0;
   end

endmodule

// Top level: lane array plus round-robin event arbiter.
module edge_event_scheduler #(
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2,
   parameter int IDW         = $clog2(N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   level,
   input  logic [N-1:0]   enable,
   output logic           evt_valid,
   input  logic           evt_ready,
   output logic [IDW-1:0] evt_id,
   output logic [N-1:0]   pending,
   output logic [N-1:0]   overflow,
   input  logic           clear_overflow
);

   typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [IDW-1:0]   id_nxt;
   logic [IDW-1:0]   last_grant, last_grant_nxt;
   logic             accept;
   logic [N-1:0]     clr;
   logic [IDW-1:0]   rr_pick;
   logic             rr_found;

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_lane
         assign clr[g] = accept && (evt_id == IDW'(g));

         edge_event_lane #(
            .SYNC_STAGES (SYNC_STAGES)
         ) u_lane (
            .clk            (clk),
            .reset          (reset),
            .level          (level[g]),
            .enable         (enable[g]),
            .clr            (clr[g]),
            .clear_overflow (clear_overflow),
            .pending        (pending[g]),
            .overflow       (overflow[g])
         );
      end
   endgenerate

   // Round-robin search: first pending channel after last_grant, with wrap.
   always_comb begin
      int             idx;
      logic [IDW-1:0] cand;
      rr_pick  = '0;
      rr_found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx  = (int'(last_grant) + k) % N;
         cand = idx[IDW-1:0];
         if (!rr_found && pending[cand]) begin
            rr_pick  = cand;
            rr_found = 1'b1;
         end
      end
   end

   // Arbiter state, offered ID and last-grant pointer. Reset drops any
   // offered event without a handshake and gives channel 0 first priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         evt_id     <= '0;
         last_grant <= IDW'(N - 1);
      end else begin
         state      <= state_nxt;
         evt_id     <= id_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // Next-state and handshake decode. evt_id only changes when leaving IDLE,
   // so it is stable for the whole OFFER phase.
   always_comb begin
      state_nxt      = state;
      id_nxt         = evt_id;
      last_grant_nxt = last_grant;
      evt_valid      = 1'b0;
      accept         = 1'b0;
      case (state)
         IDLE: begin
            if (rr_found) begin
               id_nxt    = rr_pick;
               state_nxt = OFFER;
            end
         end
         OFFER: begin
            evt_valid = 1'b1;
            if (evt_ready) begin
               accept         = 1'b1;
               last_grant_nxt = evt_id;
               state_nxt      = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
